ring_output_port: RTL and testbench
===================================

RING_OUTPUT_PORT -- requirements
Module: ring_output_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning packet width in bits.
REQ-002 SHALL have parameter NUM_IN, default 4, meaning number of requesting input channels (range 2..8).
REQ-003 SHALL have parameter HOP_LSB, default 48, meaning LSB position of the hop field in the packet.
REQ-004 SHALL have parameter HOP_WIDTH, default 8, meaning width of the hop field.
REQ-005 SHALL have parameter HOP_MODE, default 0, meaning hop update rule (0 = logical shift right by 1; 1 = saturating decrement by 1).
REQ-006 SHALL have port clk, input, 1 bit, meaning clock; all state SHALL update on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-008 SHALL have port polarity, input, 1 bit, meaning link phase; 0 = even VC may transmit, 1 = odd VC may transmit.
REQ-009 SHALL have port req_even, input, NUM_IN bits, meaning per-channel even-VC request.
REQ-010 SHALL have port req_odd, input, NUM_IN bits, meaning per-channel odd-VC request.
REQ-011 SHALL have port data_even, input, NUM_IN*DATA_WIDTH bits, meaning even-VC packets; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port data_odd, input, NUM_IN*DATA_WIDTH bits, meaning odd-VC packets, packed as data_even.
REQ-013 SHALL have port grant_even, output, NUM_IN bits, meaning one-hot, single-cycle pulse; the packet of the indicated channel was captured.
REQ-014 SHALL have port grant_odd, output, NUM_IN bits, meaning odd-VC equivalent of grant_even.
REQ-015 SHALL have port ro, input, 1 bit, meaning downstream ready for the VC selected by polarity.
REQ-016 SHALL have port so, output, 1 bit, meaning output packet valid for one cycle.
REQ-017 SHALL have port dout, output, DATA_WIDTH bits, meaning output packet.

Function
REQ-018 Each VC SHALL own a one-entry buffer with FSM states EMPTY and FULL, plus a round-robin pointer rr of width clog2(NUM_IN).
REQ-019 In EMPTY with any req bit set, the VC SHALL pick the first requesting channel at or after rr (wrapping at NUM_IN).
REQ-020 On that pick, the VC SHALL capture the winner's data, pulse grant[winner] for exactly that cycle, go FULL next cycle, and set rr to (winner+1) mod NUM_IN.
REQ-021 In FULL, the VC SHALL issue no grant and ignore requests.
REQ-022 A VC SHALL transmit in a cycle when it is FULL, it is the VC selected by polarity, and ro=1.
REQ-023 On transmit, dout/so SHALL register on the next edge (1-cycle latency): dout = buffer with the hop field updated per HOP_MODE, all other bits unchanged; so=1 for one cycle; the VC SHALL return to EMPTY.
REQ-024 A transmit and a new capture on the same VC in the same cycle SHALL be allowed (drain-and-refill): the buffer stays FULL with new data, and a grant SHALL pulse.
REQ-025 HOP_MODE=1 SHALL leave a hop value of 0 at 0 (saturate); HOP_MODE=0 SHALL shift a zero fill into the MSB.
REQ-026 When no transmit occurs, so SHALL be 0 and dout SHALL hold its last value.
REQ-027 The even and odd VCs SHALL arbitrate independently and simultaneously; at most one VC SHALL transmit per cycle (guaranteed by polarity).
REQ-028 A requester that still holds req high in the cycle after its grant SHALL be treated as presenting a new packet.

Reset
REQ-029 While rst=1: both VCs EMPTY, rr=0, grant_even=grant_odd=0, so=0, dout=0, buffers=0.
REQ-030 A reset asserted while a VC is FULL SHALL discard the buffered packet without emitting it.
REQ-031 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-032 The VC state encoding, HOP_MODE encodings and the hop-update function SHALL be placed in a shared package, ring_pkg.
REQ-033 Each VC SHALL be one instance of sub-module ring_vc_arb (round-robin pick, buffer, FSM), instantiated twice; top level SHALL contain only the polarity mux and output register.

Verification
REQ-034 Scenario: NUM_IN=4, req_even=4'b1111 held, polarity toggling each cycle, ro=1 -> grants in order ch0,ch1,ch2,ch3,ch0; dout sequence matches; no loss.
REQ-035 Scenario: packet hop field 8'b0000_0100, HOP_MODE=0 -> dout hop field = 8'b0000_0010; HOP_MODE=1 with hop 0 -> hop field 0.
REQ-036 Scenario: even VC FULL, ro=0 for 5 cycles -> so=0 and no further grant_even; on ro=1 with polarity=0 -> so=1 the next cycle.
REQ-037 Scenario: req_even=4'b0001 and req_odd=4'b0010 in the same cycle -> grant_even=0001 and grant_odd=0010 in that same cycle; outputs emitted on the respective polarity phases.
REQ-038 Scenario: rst asserted while both VCs are FULL -> so never pulses for the discarded packets; rr=0 and the next request from ch2 alone is granted in the first cycle after reset.
REQ-039 Scenario: drain-and-refill (FULL, polarity match, ro=1, req pending) -> so=1 and grant pulse occur on adjacent edges; the new packet is emitted on the next matching phase.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the ring output port: VC buffer states, hop-update
// modes and the hop-update rule applied to outgoing packets.
package ring_pkg;

  typedef enum logic {
    VC_EMPTY = 1'b0,
    VC_FULL  = 1'b1
  } vc_state_e;

  localparam int HOP_SHIFT  = 0;  // logical shift right by one, zero fill
  localparam int HOP_SATDEC = 1;  // decrement by one, saturating at zero

  // Hop values travel zero-extended in a 32-bit container; callers truncate.
  function automatic logic [31:0] hop_update(input logic [31:0] hop, input int mode);
    if (mode == HOP_SATDEC) begin
      return (hop == 32'd0) ? 32'd0 : hop - 32'd1;
    end
    return hop >> 1;
  endfunction

endpackage

// File: rtl/ring_vc_arb.sv
// One virtual channel: round-robin pick among requesters, one-entry packet
// buffer and its EMPTY/FULL state machine. Grants are combinational pulses.
module ring_vc_arb
  import ring_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data,
  input  logic                         tx,
  output logic [NUM_IN-1:0]            grant,
  output logic                         full,
  output logic [DATA_WIDTH-1:0]        buf_q
);

  localparam int RR_W = $clog2(NUM_IN);

  vc_state_e       state, state_next;
  logic [RR_W-1:0] rr, winner;
  logic            any_req, take;
  int              idx;

  // Scan from the highest offset down so the last hit is the first requester at/after rr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner  = rr;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_IN;
      if (req[idx]) begin
        winner  = RR_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  // A capture is allowed when empty, or when the buffer drains this same cycle.
  assign take = !rst && any_req && (state == VC_EMPTY || tx);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= VC_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      VC_EMPTY: if (take) state_next = VC_FULL;
      VC_FULL:  if (tx && !take) state_next = VC_EMPTY;
      default:  state_next = VC_EMPTY;
    endcase
  end

  always_comb begin
    grant         = '0;
    grant[winner] = take;
    full          = (state == VC_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr    <= '0;
      buf_q <= '0;
    end else if (take) begin
      buf_q <= data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      rr    <= (int'(winner) == NUM_IN - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/ring_output_port.sv
// Ring output port: two independently arbitrated VCs share one output link;
// polarity picks which VC may drain, and the output is registered once.
module ring_output_port
  import ring_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN     = 4,
  parameter int HOP_LSB    = 48,
  parameter int HOP_WIDTH  = 8,
  parameter int HOP_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         polarity,
  input  logic [NUM_IN-1:0]            req_even,
  input  logic [NUM_IN-1:0]            req_odd,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_even,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_odd,
  output logic [NUM_IN-1:0]            grant_even,
  output logic [NUM_IN-1:0]            grant_odd,
  input  logic                         ro,
  output logic                         so,
  output logic [DATA_WIDTH-1:0]        dout
);

  logic                  full_even, full_odd, tx_even, tx_odd, tx_any;
  logic [DATA_WIDTH-1:0] buf_even, buf_odd, sel_buf, next_dout;
  logic [31:0]           hop_in;
  logic [HOP_WIDTH-1:0]  hop_out;

  assign tx_even = full_even && !polarity && ro;
  assign tx_odd  = full_odd  &&  polarity && ro;
  assign tx_any  = tx_even || tx_odd;

  ring_vc_arb #(.DATA_WIDTH(DATA_WIDTH), .NUM_IN(NUM_IN)) u_vc_even (
    .clk   (clk),
    .rst   (rst),
    .req   (req_even),
    .data  (data_even),
    .tx    (tx_even),
    .grant (grant_even),
    .full  (full_even),
    .buf_q (buf_even)
  );

  ring_vc_arb #(.DATA_WIDTH(DATA_WIDTH), .NUM_IN(NUM_IN)) u_vc_odd (
    .clk   (clk),
    .rst   (rst),
    .req   (req_odd),
    .data  (data_odd),
    .tx    (tx_odd),
    .grant (grant_odd),
    .full  (full_odd),
    .buf_q (buf_odd)
  );

  always_comb begin
    sel_buf   = polarity ? buf_odd : buf_even;
    hop_in    = 32'(sel_buf[HOP_LSB +: HOP_WIDTH]);
    hop_out   = HOP_WIDTH'(hop_update(hop_in, HOP_MODE));
    next_dout = sel_buf;
    next_dout[HOP_LSB +: HOP_WIDTH] = hop_out;
  end

  // dout only moves on a transmit, so it holds the last packet between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      so   <= 1'b0;
      dout <= '0;
    end else begin
      so <= tx_any;
      if (tx_any) dout <= next_dout;
    end
  end

endmodule

// File: tb/tb_ring_output_port.sv
// Self-checking bench: two DUTs (HOP_MODE 0 and 1) on shared stimulus, checked
// against a packet-level reference model plus scenario-specific checks.
module tb_ring_output_port;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int HL = 48;
  localparam int HW = 8;

  logic              clk = 1'b0;
  logic              rst, polarity, ro;
  logic [N-1:0]      req_even, req_odd;
  logic [N*DW-1:0]   data_even, data_odd;
  logic [N-1:0]      ge0, go0, ge1, go1;
  logic              so0, so1;
  logic [DW-1:0]     dout0, dout1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per VC, "holding a packet?" plus that packet and the next-priority channel.
  bit            m_full [2];
  logic [DW-1:0] m_buf  [2];
  int            m_rr   [2];
  logic          m_so;
  logic [DW-1:0] m_dout [2];
  logic [N-1:0]  seen_ge, seen_go;

  always #5 clk = ~clk;

  ring_output_port #(.DATA_WIDTH(DW), .NUM_IN(N), .HOP_LSB(HL), .HOP_WIDTH(HW), .HOP_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .polarity(polarity), .req_even(req_even), .req_odd(req_odd),
    .data_even(data_even), .data_odd(data_odd), .grant_even(ge0), .grant_odd(go0),
    .ro(ro), .so(so0), .dout(dout0)
  );

  ring_output_port #(.DATA_WIDTH(DW), .NUM_IN(N), .HOP_LSB(HL), .HOP_WIDTH(HW), .HOP_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .polarity(polarity), .req_even(req_even), .req_odd(req_odd),
    .data_even(data_even), .data_odd(data_odd), .grant_even(ge1), .grant_odd(go1),
    .ro(ro), .so(so1), .dout(dout1)
  );

  function automatic int pick(input int rr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] hop_ref(input logic [DW-1:0] d, input int mode);
    logic [DW-1:0] r;
    int h;
    h = int'(d[HL +: HW]);
    if (mode == 1) h = (h == 0) ? 0 : h - 1;
    else           h = h / 2;
    r = d;
    r[HL +: HW] = HW'(h);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      data_even[i*DW +: DW] = rnd64();
      data_odd[i*DW +: DW]  = rnd64();
    end
  endtask

  // One clock of stimulus: grants compared before the edge, so/dout after it.
  task automatic cycle();
    int              w  [2];
    bit              tx [2];
    logic [N-1:0]    eg [2];
    logic [N-1:0]    rq [2];
    logic [N*DW-1:0] dv [2];
    int              sel;
    #1;
    rq[0] = req_even;  rq[1] = req_odd;
    dv[0] = data_even; dv[1] = data_odd;
    for (int v = 0; v < 2; v++) begin
      tx[v] = 1'b0; w[v] = -1; eg[v] = '0;
      if (!rst) begin
        tx[v] = m_full[v] && (int'(polarity) == v) && ro;
        if (!m_full[v] || tx[v]) w[v] = pick(m_rr[v], rq[v]);
        if (w[v] >= 0) eg[v][w[v]] = 1'b1;
      end
    end
    n_checks++; if (ge0 !== eg[0]) $display("FAIL grant_even m0: got %b expected %b", ge0, eg[0]); else n_pass++;
    n_checks++; if (go0 !== eg[1]) $display("FAIL grant_odd m0: got %b expected %b", go0, eg[1]); else n_pass++;
    n_checks++; if (ge1 !== eg[0]) $display("FAIL grant_even m1: got %b expected %b", ge1, eg[0]); else n_pass++;
    n_checks++; if (go1 !== eg[1]) $display("FAIL grant_odd m1: got %b expected %b", go1, eg[1]); else n_pass++;
    seen_ge = ge0;
    seen_go = go0;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        m_full[v] = 1'b0; m_buf[v] = '0; m_rr[v] = 0; m_dout[v] = '0;
      end
      m_so = 1'b0;
    end else begin
      m_so = tx[0] || tx[1];
      sel  = tx[1] ? 1 : 0;
      if (m_so) begin
        m_dout[0] = hop_ref(m_buf[sel], 0);
        m_dout[1] = hop_ref(m_buf[sel], 1);
      end
      for (int v = 0; v < 2; v++) begin
        if (w[v] >= 0) begin
          m_full[v] = 1'b1;
          m_buf[v]  = dv[v][w[v]*DW +: DW];
          m_rr[v]   = (w[v] + 1) % N;
        end else if (tx[v]) begin
          m_full[v] = 1'b0;
        end
      end
    end
    n_checks++; if (so0 !== m_so) $display("FAIL so m0: got %b expected %b", so0, m_so); else n_pass++;
    n_checks++; if (so1 !== m_so) $display("FAIL so m1: got %b expected %b", so1, m_so); else n_pass++;
    n_checks++; if (dout0 !== m_dout[0]) $display("FAIL dout m0: got %h expected %h", dout0, m_dout[0]); else n_pass++;
    n_checks++; if (dout1 !== m_dout[1]) $display("FAIL dout m1: got %h expected %h", dout1, m_dout[1]); else n_pass++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_even = '0; req_odd = '0; ro = 1'b0; polarity = 1'b0;
    rand_data();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (so0 !== 1'b0 || so1 !== 1'b0) $display("FAIL reset_so: got %b/%b expected 0", so0, so1); else n_pass++;
    n_checks++; if (dout0 !== '0 || dout1 !== '0) $display("FAIL reset_dout: got %h/%h expected 0", dout0, dout1); else n_pass++;
  endtask

  task automatic test_rr_sweep();
    int k;
    apply_reset();
    req_even = 4'b1111; ro = 1'b1; polarity = 1'b0; k = 0;
    for (int c = 0; c < 12 && k < 5; c++) begin
      rand_data();
      cycle();
      if (seen_ge != '0) begin
        n_checks++;
        if (seen_ge !== N'(1 << (k % N))) $display("FAIL rr_order[%0d]: got %b expected %b", k, seen_ge, N'(1 << (k % N)));
        else n_pass++;
        k++;
      end
      polarity = ~polarity;
    end
    n_checks++; if (k != 5) $display("FAIL rr_grant_count: got %0d expected 5", k); else n_pass++;
    req_even = '0;
    repeat (3) begin cycle(); polarity = ~polarity; end
  endtask

  task automatic test_hop();
    logic [DW-1:0] w;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      w = rnd64();
      w[HL +: HW] = (pass == 0) ? 8'b0000_0100 : 8'b0000_0000;
      data_even[0 +: DW] = w;
      req_even = 4'b0001; polarity = 1'b1; ro = 1'b1;
      cycle();
      req_even = '0; polarity = 1'b0;
      cycle();
      n_checks++;
      if (dout0[HL +: HW] !== ((pass == 0) ? 8'h02 : 8'h00)) $display("FAIL hop_shift[%0d]: got %h", pass, dout0[HL +: HW]);
      else n_pass++;
      n_checks++;
      if (dout1[HL +: HW] !== ((pass == 0) ? 8'h03 : 8'h00)) $display("FAIL hop_satdec[%0d]: got %h", pass, dout1[HL +: HW]);
      else n_pass++;
      w[HL +: HW] = dout0[HL +: HW];
      n_checks++; if (dout0 !== w) $display("FAIL hop_other_bits: got %h expected %h", dout0, w); else n_pass++;
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req_even = 4'b0010; polarity = 1'b1; ro = 1'b1;
    rand_data();
    cycle();
    ro = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_even = N'($urandom_range(1, 15)); polarity = 1'($urandom);
      rand_data();
      cycle();
      n_checks++;
      if (seen_ge !== '0 || so0 !== 1'b0) $display("FAIL stall[%0d]: got grant %b so %b expected 0/0", c, seen_ge, so0);
      else n_pass++;
    end
    req_even = '0; ro = 1'b1; polarity = 1'b0;
    cycle();
    n_checks++; if (so0 !== 1'b1) $display("FAIL stall_release: got so %b expected 1", so0); else n_pass++;
  endtask

  task automatic test_dual();
    apply_reset();
    req_even = 4'b0001; req_odd = 4'b0010; polarity = 1'b1; ro = 1'b0;
    rand_data();
    cycle();
    n_checks++;
    if (seen_ge !== 4'b0001 || seen_go !== 4'b0010) $display("FAIL dual_grant: got %b/%b expected 0001/0010", seen_ge, seen_go);
    else n_pass++;
    req_even = '0; req_odd = '0; ro = 1'b1; polarity = 1'b0;
    cycle();
    n_checks++; if (so0 !== 1'b1) $display("FAIL dual_even_out: got so %b expected 1", so0); else n_pass++;
    polarity = 1'b1;
    cycle();
    n_checks++; if (so0 !== 1'b1) $display("FAIL dual_odd_out: got so %b expected 1", so0); else n_pass++;
  endtask

  task automatic test_reset_full();
    int pulses;
    apply_reset();
    req_even = 4'b0001; req_odd = 4'b0001; ro = 1'b0;
    rand_data();
    cycle();
    rst = 1'b1; req_even = 4'b0100; req_odd = '0; ro = 1'b1;
    for (int c = 0; c < 2; c++) begin
      polarity = 1'(c);
      cycle();
      n_checks++;
      if (seen_ge !== '0 || so0 !== 1'b0) $display("FAIL rst_full[%0d]: got grant %b so %b expected 0/0", c, seen_ge, so0);
      else n_pass++;
    end
    rst = 1'b0; polarity = 1'b1;
    cycle();
    n_checks++; if (seen_ge !== 4'b0100) $display("FAIL post_rst_grant: got %b expected 0100", seen_ge); else n_pass++;
    req_even = '0; pulses = 0;
    for (int c = 0; c < 4; c++) begin
      polarity = 1'(c);
      cycle();
      if (so0 === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) $display("FAIL post_rst_pulses: got %0d expected 1", pulses); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] refill;
    apply_reset();
    req_even = 4'b0001; polarity = 1'b1; ro = 1'b1;
    rand_data();
    cycle();
    req_even = 4'b0010; polarity = 1'b0;
    rand_data();
    refill = data_even[DW +: DW];
    cycle();
    n_checks++; if (seen_ge !== 4'b0010) $display("FAIL refill_grant: got %b expected 0010", seen_ge); else n_pass++;
    n_checks++; if (so0 !== 1'b1) $display("FAIL refill_drain: got so %b expected 1", so0); else n_pass++;
    req_even = '0; polarity = 1'b1;
    cycle();
    polarity = 1'b0;
    cycle();
    n_checks++;
    if (so0 !== 1'b1 || dout0 !== hop_ref(refill, 0)) $display("FAIL refill_out: got so %b dout %h expected 1 %h", so0, dout0, hop_ref(refill, 0));
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      polarity = 1'($urandom);
      ro       = ($urandom_range(0, 3) != 0);
      req_even = N'($urandom);
      req_odd  = N'($urandom);
      rand_data();
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_hop();
    test_stall();
    test_dual();
    test_reset_full();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
